// File: rtl/gate_check_pkg.sv
// Shared types and helpers for the gate-network checkers.
package gate_check_pkg;

  // Widest table the helpers accept (N_IN up to 8).
  localparam int unsigned MAX_TBL_W = 256;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    DONE
  } sweep_state_t;

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic int unsigned lowest_set(input logic [MAX_TBL_W-1:0] v);
    int unsigned r;
    r = 0;
    for (int i = int'(MAX_TBL_W) - 1; i >= 0; i--) begin
      if (v[i]) r = unsigned'(i);
    end
    return r;
  endfunction

  function automatic int unsigned popcount(input logic [MAX_TBL_W-1:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < int'(MAX_TBL_W); i++) begin
      c += {31'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter: load sets SETTLE-1, en counts down, zero_c flags expiry.
module settle_timer #(
  parameter int unsigned SETTLE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic zero_c
);

  localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(SETTLE - 1);
    end else if (en && !zero_c) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign zero_c = (cnt == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives every input vector of a small gate network in order, captures its
// output per vector and compares the resulting truth table against a golden one.
module truth_table_sweeper
  import gate_check_pkg::*;
#(
  parameter int unsigned N_IN   = 3,
  parameter int unsigned SETTLE = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [(2**N_IN)-1:0]   expected,
  output logic [N_IN-1:0]        dut_in,
  input  logic                   dut_out,
  output logic                   busy,
  output logic                   done,
  output logic [(2**N_IN)-1:0]   truth_table,
  output logic                   match,
  output logic [N_IN:0]          mismatch_cnt,
  output logic [N_IN-1:0]        fail_idx
);

  localparam int unsigned TBL_W = 2 ** N_IN;
  localparam int unsigned IW    = N_IN + 1;

  sweep_state_t state, state_next;

  logic [IW-1:0]    idx;
  logic [TBL_W-1:0] exp_q;
  logic [TBL_W-1:0] final_tbl;
  logic [TBL_W-1:0] diff;
  logic             accept;
  logic             timer_load;
  logic             timer_en;
  logic             capture;
  logic             last_c;
  logic             zero_c;

  settle_timer #(
    .SETTLE (SETTLE)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (timer_load),
    .en     (timer_en),
    .zero_c (zero_c)
  );

  assign last_c = (idx == IW'(TBL_W - 1));

  // Table as it will look after the current capture, so results include the last bit.
  always_comb begin
    final_tbl = truth_table;
    final_tbl[idx[N_IN-1:0]] = dut_out;
    diff = final_tbl ^ exp_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    timer_load = 1'b0;
    timer_en   = 1'b0;
    capture    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          timer_load = 1'b1;
          state_next = DRIVE;
        end
      end
      DRIVE: begin
        timer_en = 1'b1;
        if (zero_c) state_next = SAMPLE;
      end
      SAMPLE: begin
        capture = 1'b1;
        if (last_c) begin
          state_next = DONE;
        end else begin
          timer_load = 1'b1;
          state_next = DRIVE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx          <= '0;
      exp_q        <= '0;
      dut_in       <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      truth_table  <= '0;
      match        <= 1'b0;
      mismatch_cnt <= '0;
      fail_idx     <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        exp_q        <= expected;
        truth_table  <= '0;
        idx          <= '0;
        dut_in       <= '0;
        busy         <= 1'b1;
        match        <= 1'b0;
        mismatch_cnt <= '0;
        fail_idx     <= '0;
      end
      if (capture) begin
        truth_table <= final_tbl;
        if (last_c) begin
          done         <= 1'b1;
          match        <= (diff == '0);
          mismatch_cnt <= IW'(popcount(MAX_TBL_W'(diff)));
          fail_idx     <= N_IN'(lowest_set(MAX_TBL_W'(diff)));
        end else begin
          idx    <= idx + IW'(1);
          dut_in <= N_IN'(idx + IW'(1));
        end
      end
      if (state == DONE) begin
        busy   <= 1'b0;
        dut_in <= '0;
      end
    end
  end

endmodule
